// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the tick-countdown arbiter and its round-robin picker.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tarb_state_t;

    localparam int TARB_NUM_REQ = 4;
    localparam int TARB_DELAY_W = 8;
    localparam int TARB_MAX_REQ = 8;
    localparam int TARB_SEL_W   = 3;

    // Callers truncate the result to their own requester count.
    function automatic logic [TARB_MAX_REQ-1:0] onehot(input logic [TARB_SEL_W-1:0] idx);
        return TARB_MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester/timer side bundle of the countdown arbiter.
interface timer_arbiter_if
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = TARB_NUM_REQ,
    parameter int DELAY_W = TARB_DELAY_W
);
    logic                       tick;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DELAY_W-1:0] delay;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         done;
    logic                       busy;
    logic [DELAY_W-1:0]         remaining;

    modport master (
        output tick, req, delay,
        input  grant, done, busy, remaining
    );

    modport slave (
        input  tick, req, delay,
        output grant, done, busy, remaining
    );
endinterface

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request above the last winner, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);
    logic [IDX_W-1:0]   cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[gi] is the requester sitting gi+1 places after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, last} + (IDX_W+1)'(gi + 1);
            assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                               IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = last;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/timer_arbiter.sv
// Shares the timer tick among requesters: grants one, counts its delay in ticks, pulses done.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = TARB_NUM_REQ,
    parameter int DELAY_W = TARB_DELAY_W
) (
    input  logic           clk,
    input  logic           rst,
    timer_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    tarb_state_t        state_reg, state_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [DELAY_W-1:0] count_reg, count_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic               busy_reg, busy_next;
    logic [DELAY_W-1:0] remaining_reg, remaining_next;
    logic [NUM_REQ-1:0] owner_hot;
    logic [IDX_W-1:0]   winner;
    logic               win_valid;
    logic [DELAY_W-1:0] delay_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign delay_slice[gi] = bus.delay[gi*DELAY_W +: DELAY_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req    (bus.req),
        .last   (last_reg),
        .winner (winner),
        .valid  (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            last_reg      <= IDX_W'(NUM_REQ - 1);
            count_reg     <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            count_reg     <= count_next;
            grant_reg     <= grant_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
            remaining_reg <= remaining_next;
        end
    end

    // Abandon outranks a coincident tick; a zero delay finishes without waiting for one.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next = RUN;
                    owner_next = winner;
                    count_next = delay_slice[winner];
                end
            end
            RUN: begin
                if (!bus.req[owner_reg]) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                    count_next = '0;
                end else if (count_reg == '0) begin
                    state_next = DONE;
                end else if (bus.tick) begin
                    count_next = count_reg - DELAY_W'(1);
                    if (count_reg == DELAY_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                last_next  = owner_reg;
                count_next = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave the module straight from flops.
    always_comb begin
        owner_hot      = NUM_REQ'(onehot(TARB_SEL_W'(owner_next)));
        busy_next      = (state_next != IDLE);
        grant_next     = busy_next ? owner_hot : '0;
        done_next      = (state_next == DONE) ? owner_hot : '0;
        remaining_next = busy_next ? count_next : '0;
    end

    assign bus.grant     = grant_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = busy_reg;
    assign bus.remaining = remaining_reg;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed vector table, round-robin sequence, random run against a model.
module tb_timer_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_arbiter_if #(.NUM_REQ(N), .DELAY_W(W)) ifc ();

    timer_arbiter #(.NUM_REQ(N), .DELAY_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct {
        logic        rst;
        logic        tick;
        logic [3:0]  req;
        logic [31:0] delay;
        logic [3:0]  grant;
        logic [3:0]  done;
        logic        busy;
        logic [7:0]  rem;
    } vec_t;

    vec_t tbl [28];
    int total = 0;
    int bad   = 0;

    // Reference model: who owns the countdown, ticks still owed, whether done is showing.
    int m_owner;
    int m_rem;
    int m_last;
    bit m_fin;

    function automatic vec_t mk(logic r, logic t, logic [3:0] q, logic [31:0] d,
                                logic [3:0] g, logic [3:0] dn, logic b, logic [7:0] rm);
        vec_t v;
        v.rst = r; v.tick = t; v.req = q; v.delay = d;
        v.grant = g; v.done = dn; v.busy = b; v.rem = rm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_rem = 0; m_fin = 1'b0; m_last = N - 1;
        end else if (m_fin) begin
            m_fin = 1'b0; m_last = m_owner; m_owner = -1; m_rem = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (ifc.req[c]) begin
                    m_owner = c;
                    m_rem   = int'(ifc.delay[c*W +: W]);
                    break;
                end
            end
        end else if (!ifc.req[m_owner]) begin
            m_last = m_owner; m_owner = -1; m_rem = 0;
        end else if (m_rem == 0) begin
            m_fin = 1'b1;
        end else if (ifc.tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_fin = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        chk("rnd_grant", 32'(ifc.grant), 32'(eg));
        chk("rnd_done", 32'(ifc.done), m_fin ? 32'(eg) : 32'h0);
        chk("rnd_busy", 32'(ifc.busy), (m_owner >= 0) ? 32'h1 : 32'h0);
        chk("rnd_remaining", 32'(ifc.remaining), (m_owner >= 0) ? 32'(m_rem) : 32'h0);
    endtask

    logic [3:0] rr_exp [5];
    int got;

    initial begin
        rst = 1'b1; ifc.tick = 1'b0; ifc.req = '0; ifc.delay = '0;

        tbl[0]  = mk(1, 0, 4'h0, 32'h0,   4'h0, 4'h0, 0, 0);
        tbl[1]  = mk(0, 0, 4'h1, 32'h3,   4'h1, 4'h0, 1, 3);
        tbl[2]  = mk(0, 0, 4'h1, 32'h3,   4'h1, 4'h0, 1, 3);
        tbl[3]  = mk(0, 1, 4'h1, 32'h3,   4'h1, 4'h0, 1, 2);
        tbl[4]  = mk(0, 0, 4'h1, 32'h3,   4'h1, 4'h0, 1, 2);
        tbl[5]  = mk(0, 1, 4'h1, 32'h3,   4'h1, 4'h0, 1, 1);
        tbl[6]  = mk(0, 0, 4'h1, 32'h3,   4'h1, 4'h0, 1, 1);
        tbl[7]  = mk(0, 1, 4'h1, 32'h3,   4'h1, 4'h1, 1, 0);
        tbl[8]  = mk(0, 0, 4'h1, 32'h3,   4'h0, 4'h0, 0, 0);
        tbl[9]  = mk(0, 0, 4'h0, 32'h3,   4'h0, 4'h0, 0, 0);
        tbl[10] = mk(0, 0, 4'h4, 32'h0,   4'h4, 4'h0, 1, 0);
        tbl[11] = mk(0, 0, 4'h4, 32'h0,   4'h4, 4'h4, 1, 0);
        tbl[12] = mk(0, 0, 4'h0, 32'h0,   4'h0, 4'h0, 0, 0);
        tbl[13] = mk(0, 1, 4'h1, 32'h2,   4'h1, 4'h0, 1, 2);
        tbl[14] = mk(0, 1, 4'h1, 32'h2,   4'h1, 4'h0, 1, 1);
        tbl[15] = mk(0, 0, 4'h1, 32'h2,   4'h1, 4'h0, 1, 1);
        tbl[16] = mk(0, 1, 4'h1, 32'h2,   4'h1, 4'h1, 1, 0);
        tbl[17] = mk(0, 0, 4'h0, 32'h2,   4'h0, 4'h0, 0, 0);
        tbl[18] = mk(0, 0, 4'h2, 32'h502, 4'h2, 4'h0, 1, 5);
        tbl[19] = mk(0, 1, 4'h2, 32'h502, 4'h2, 4'h0, 1, 4);
        tbl[20] = mk(0, 1, 4'h2, 32'h502, 4'h2, 4'h0, 1, 3);
        tbl[21] = mk(0, 1, 4'h0, 32'h502, 4'h0, 4'h0, 0, 0);
        tbl[22] = mk(0, 0, 4'h3, 32'h502, 4'h1, 4'h0, 1, 2);
        tbl[23] = mk(0, 0, 4'h0, 32'h502, 4'h0, 4'h0, 0, 0);
        tbl[24] = mk(0, 0, 4'h1, 32'h4,   4'h1, 4'h0, 1, 4);
        tbl[25] = mk(1, 0, 4'h1, 32'h4,   4'h0, 4'h0, 0, 0);
        tbl[26] = mk(0, 0, 4'h9, 32'h4,   4'h1, 4'h0, 1, 4);
        tbl[27] = mk(0, 0, 4'h0, 32'h4,   4'h0, 4'h0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            rst = tbl[i].rst; ifc.tick = tbl[i].tick;
            ifc.req = tbl[i].req; ifc.delay = tbl[i].delay;
            cycle();
            $display("vec %0d: grant=%b done=%b busy=%b remaining=%0d",
                     i, ifc.grant, ifc.done, ifc.busy, ifc.remaining);
            chk($sformatf("vec%0d_grant", i), 32'(ifc.grant), 32'(tbl[i].grant));
            chk($sformatf("vec%0d_done", i), 32'(ifc.done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_busy", i), 32'(ifc.busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_remaining", i), 32'(ifc.remaining), 32'(tbl[i].rem));
        end

        // All four requesting with unit delays: service order must rotate.
        rr_exp[0] = 4'h1; rr_exp[1] = 4'h2; rr_exp[2] = 4'h4; rr_exp[3] = 4'h8; rr_exp[4] = 4'h1;
        rst = 1'b1; ifc.req = '0; ifc.tick = 1'b0;
        cycle();
        rst = 1'b0; ifc.req = 4'hF; ifc.delay = 32'h01010101;
        got = 0;
        for (int c = 0; c < 200 && got < 5; c++) begin
            ifc.tick = (c % 3 == 2);
            cycle();
            if (ifc.done != 4'h0) begin
                $display("rr done %0d: done=%b grant=%b", got, ifc.done, ifc.grant);
                chk("rr_done_order", 32'(ifc.done), 32'(rr_exp[got]));
                chk("rr_grant_order", 32'(ifc.grant), 32'(rr_exp[got]));
                got++;
            end
        end
        chk("rr_done_count", 32'(got), 32'd5);

        // Random traffic against the model, including delay churn after grant and stray resets.
        rst = 1'b1; ifc.req = '0; ifc.tick = 1'b0;
        cycle();
        check_model();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int bit_idx;
            rst = ($urandom_range(0, 299) == 0);
            ifc.tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bit_idx = $urandom_range(0, N - 1);
                ifc.req[bit_idx] = ~ifc.req[bit_idx];
            end
            ifc.delay = $urandom & 32'h03030303;
            cycle();
            check_model();
            if (ifc.done != 4'h0)
                $display("rnd cycle %0d: done=%b", c, ifc.done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
